// File: rtl/axil_pkg.sv
// ---------------------------------------------------------------------------
// axil_pkg
// Shared types and helpers for the AXI4-Lite register slave.
//   resp_t       : AXI response codes carried on BRESP / RRESP.
//   addr_to_idx  : turns a byte address into a register index by dropping
//                  the byte-lane bits below the word boundary.
// ---------------------------------------------------------------------------
package axil_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    // The index is returned 64 bits wide so callers can range-check it
    // against the register count without losing any address bits.
    function automatic logic [63:0] addr_to_idx(input logic [63:0] addr,
                                                input int unsigned lsb);
        return addr >> lsb;
    endfunction

endpackage

// File: rtl/axil_hold_reg.sv
// ---------------------------------------------------------------------------
// axil_hold_reg
// One-entry holding register for an AXI channel payload. A beat that is
// handshaken while nobody consumes it is parked here until consume_i fires.
// A beat consumed in the same cycle it arrives is passed straight through
// and never parked.
// Ports:
//   clk_i      clock
//   rst_i      synchronous active-high reset, drops any parked beat
//   valid_i    channel VALID from the master
//   ready_i    channel READY as driven back to the master
//   payload_i  channel payload from the master
//   consume_i  the downstream logic uses the available beat this cycle
//   held_o     a beat is parked
//   avail_o    a beat is available (parked or arriving now)
//   payload_o  payload of the available beat
// ---------------------------------------------------------------------------
module axil_hold_reg
    import axil_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic             ready_i,
    input  logic [WIDTH-1:0] payload_i,
    input  logic             consume_i,
    output logic             held_o,
    output logic             avail_o,
    output logic [WIDTH-1:0] payload_o
);

    logic             held_q;
    logic             held_d;
    logic [WIDTH-1:0] payload_q;
    logic [WIDTH-1:0] payload_d;
    logic             handshake;

    assign handshake = valid_i && ready_i;
    assign held_o    = held_q;
    assign avail_o   = held_q || handshake;
    assign payload_o = held_q ? payload_q : payload_i;

    // Consume wins over capture: a beat used in its arrival cycle must not
    // leave the held flag set behind it.
    always_comb begin
        held_d    = held_q;
        payload_d = payload_q;
        if (consume_i) begin
            held_d = 1'b0;
        end else if (handshake) begin
            held_d    = 1'b1;
            payload_d = payload_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            held_q    <= 1'b0;
            payload_q <= '0;
        end else begin
            held_q    <= held_d;
            payload_q <= payload_d;
        end
    end

endmodule

// File: rtl/axil_reg_slave.sv
// ---------------------------------------------------------------------------
// axil_reg_slave
// AXI4-Lite slave exposing NUM_REGS software-visible registers. AW and W are
// accepted independently and paired in order; each pair commits one
// byte-strobed write and produces one B response. Reads return one cycle
// after the AR handshake.
// Ports:
//   aclk, arst               clock, synchronous active-high reset
//   s_axil_aw*               write address channel (awprot ignored)
//   s_axil_w*                write data channel
//   s_axil_b*                write response channel
//   s_axil_ar*               read address channel (arprot ignored)
//   s_axil_r*                read data channel
//   reg_out                  flattened register contents, reg i at
//                            [i*DATA_WIDTH +: DATA_WIDTH]
//   reg_wr                   one-cycle pulse per register after its commit
// ---------------------------------------------------------------------------
module axil_reg_slave
    import axil_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    STRB_WIDTH = DATA_WIDTH / 8,
    parameter int                    NUM_REGS   = 16,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic                           aclk,
    input  logic                           arst,
    input  logic [ADDR_WIDTH-1:0]          s_axil_awaddr,
    input  logic [2:0]                     s_axil_awprot,
    input  logic                           s_axil_awvalid,
    output logic                           s_axil_awready,
    input  logic [DATA_WIDTH-1:0]          s_axil_wdata,
    input  logic [STRB_WIDTH-1:0]          s_axil_wstrb,
    input  logic                           s_axil_wvalid,
    output logic                           s_axil_wready,
    output logic [1:0]                     s_axil_bresp,
    output logic                           s_axil_bvalid,
    input  logic                           s_axil_bready,
    input  logic [ADDR_WIDTH-1:0]          s_axil_araddr,
    input  logic [2:0]                     s_axil_arprot,
    input  logic                           s_axil_arvalid,
    output logic                           s_axil_arready,
    output logic [DATA_WIDTH-1:0]          s_axil_rdata,
    output logic [1:0]                     s_axil_rresp,
    output logic                           s_axil_rvalid,
    input  logic                           s_axil_rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    output logic [NUM_REGS-1:0]            reg_wr
);

    localparam int unsigned ADDR_LSB  = $clog2(STRB_WIDTH);
    localparam int          SEL_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int          W_PAYLOAD = DATA_WIDTH + STRB_WIDTH;

    logic [DATA_WIDTH-1:0] regFile_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regFile_d [NUM_REGS];
    logic [NUM_REGS-1:0]   regWr_q;
    logic [NUM_REGS-1:0]   regWr_d;
    logic                  bvalid_q;
    logic                  bvalid_d;
    resp_t                 bresp_q;
    resp_t                 bresp_d;
    logic                  rvalid_q;
    logic                  rvalid_d;
    resp_t                 rresp_q;
    resp_t                 rresp_d;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] rdata_d;

    logic                  awHeld;
    logic                  awAvail;
    logic [ADDR_WIDTH-1:0] awAddr;
    logic                  wHeld;
    logic                  wAvail;
    logic [W_PAYLOAD-1:0]  wPayload;
    logic                  commit;
    logic                  arHs;

    logic [63:0]           wrIdx;
    logic                  wrInRange;
    logic [SEL_W-1:0]      wrSel;
    logic [DATA_WIDTH-1:0] wrData;
    logic [STRB_WIDTH-1:0] wrStrb;
    logic [63:0]           rdIdx;
    logic                  rdInRange;
    logic [SEL_W-1:0]      rdSel;
    logic                  unusedBits;

    // Channel ready signals. Address/data readiness only reflects whether
    // the one-entry holder is free; the read side accepts a new AR whenever
    // the current R beat is leaving, giving back-to-back reads.
    assign s_axil_awready = !awHeld && !arst;
    assign s_axil_wready  = !wHeld && !arst;
    assign s_axil_arready = (!rvalid_q || s_axil_rready) && !arst;
    assign arHs           = s_axil_arvalid && s_axil_arready;

    axil_hold_reg #(.WIDTH(ADDR_WIDTH)) awHold (
        .clk_i     (aclk),
        .rst_i     (arst),
        .valid_i   (s_axil_awvalid),
        .ready_i   (s_axil_awready),
        .payload_i (s_axil_awaddr),
        .consume_i (commit),
        .held_o    (awHeld),
        .avail_o   (awAvail),
        .payload_o (awAddr)
    );

    axil_hold_reg #(.WIDTH(W_PAYLOAD)) wHold (
        .clk_i     (aclk),
        .rst_i     (arst),
        .valid_i   (s_axil_wvalid),
        .ready_i   (s_axil_wready),
        .payload_i ({s_axil_wstrb, s_axil_wdata}),
        .consume_i (commit),
        .held_o    (wHeld),
        .avail_o   (wAvail),
        .payload_o (wPayload)
    );

    // A write commits once both halves are available and the B slot is free
    // or being emptied this cycle.
    assign commit = awAvail && wAvail && (!bvalid_q || s_axil_bready);

    assign wrIdx     = addr_to_idx(64'(awAddr), ADDR_LSB);
    assign wrInRange = wrIdx < 64'(NUM_REGS);
    assign wrSel     = wrIdx[SEL_W-1:0];
    assign wrData    = wPayload[DATA_WIDTH-1:0];
    assign wrStrb    = wPayload[DATA_WIDTH +: STRB_WIDTH];

    assign rdIdx     = addr_to_idx(64'(s_axil_araddr), ADDR_LSB);
    assign rdInRange = rdIdx < 64'(NUM_REGS);
    assign rdSel     = rdIdx[SEL_W-1:0];

    // Protection bits and the upper index bits carry no meaning here.
    assign unusedBits = ^{s_axil_awprot, s_axil_arprot, wrIdx, rdIdx};

    // Byte-strobed register update. Out-of-range commits still answer on B
    // but touch no register and raise no write pulse.
    always_comb begin
        regFile_d = regFile_q;
        regWr_d   = '0;
        if (commit && wrInRange) begin
            for (int k = 0; k < STRB_WIDTH; k++) begin
                if (wrStrb[k]) begin
                    regFile_d[wrSel][k*8 +: 8] = wrData[k*8 +: 8];
                end
            end
            regWr_d[wrSel] = 1'b1;
        end
    end

    // Write response: a new commit refills B in the same cycle the old
    // response is accepted, so B never shows a bubble between writes.
    always_comb begin
        bvalid_d = bvalid_q;
        bresp_d  = bresp_q;
        if (commit) begin
            bvalid_d = 1'b1;
            bresp_d  = wrInRange ? OKAY : SLVERR;
        end else if (s_axil_bready) begin
            bvalid_d = 1'b0;
        end
    end

    // Read response samples the register file as it stands before this
    // edge, so a same-edge write to the same register is not visible yet.
    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (arHs) begin
            rvalid_d = 1'b1;
            rdata_d  = rdInRange ? regFile_q[rdSel] : '0;
            rresp_d  = rdInRange ? OKAY : SLVERR;
        end else if (s_axil_rready) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (arst) begin
            regFile_q <= '{default: RESET_VAL};
            regWr_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= OKAY;
            rvalid_q  <= 1'b0;
            rresp_q   <= OKAY;
            rdata_q   <= '0;
        end else begin
            regFile_q <= regFile_d;
            regWr_q   <= regWr_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
        end
    end

    assign s_axil_bvalid = bvalid_q;
    assign s_axil_bresp  = bresp_q;
    assign s_axil_rvalid = rvalid_q;
    assign s_axil_rresp  = rresp_q;
    assign s_axil_rdata  = rdata_q;
    assign reg_wr        = regWr_q;

    for (genvar i = 0; i < NUM_REGS; i++) begin : gRegOut
        assign reg_out[i*DATA_WIDTH +: DATA_WIDTH] = regFile_q[i];
    end

endmodule

// File: tb/tb_axil_reg_slave.sv
// ---------------------------------------------------------------------------
// tb_axil_reg_slave
// Directed bench for axil_reg_slave (32-bit data, 16 registers). A
// transaction-level model (address/data queues, a register array, one
// pending B and one pending R) predicts every output each cycle; directed
// sequences add literal expectations on top.
// ---------------------------------------------------------------------------
module tb_axil_reg_slave;

    localparam logic [31:0] RESET_VAL = 32'h0;

    logic          aclk;
    logic          arst;
    logic [15:0]   s_axil_awaddr;
    logic [2:0]    s_axil_awprot;
    logic          s_axil_awvalid;
    logic          s_axil_awready;
    logic [31:0]   s_axil_wdata;
    logic [3:0]    s_axil_wstrb;
    logic          s_axil_wvalid;
    logic          s_axil_wready;
    logic [1:0]    s_axil_bresp;
    logic          s_axil_bvalid;
    logic          s_axil_bready;
    logic [15:0]   s_axil_araddr;
    logic [2:0]    s_axil_arprot;
    logic          s_axil_arvalid;
    logic          s_axil_arready;
    logic [31:0]   s_axil_rdata;
    logic [1:0]    s_axil_rresp;
    logic          s_axil_rvalid;
    logic          s_axil_rready;
    logic [511:0]  reg_out;
    logic [15:0]   reg_wr;

    axil_reg_slave #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (16),
        .NUM_REGS   (16),
        .RESET_VAL  (RESET_VAL)
    ) dut (
        .aclk           (aclk),
        .arst           (arst),
        .s_axil_awaddr  (s_axil_awaddr),
        .s_axil_awprot  (s_axil_awprot),
        .s_axil_awvalid (s_axil_awvalid),
        .s_axil_awready (s_axil_awready),
        .s_axil_wdata   (s_axil_wdata),
        .s_axil_wstrb   (s_axil_wstrb),
        .s_axil_wvalid  (s_axil_wvalid),
        .s_axil_wready  (s_axil_wready),
        .s_axil_bresp   (s_axil_bresp),
        .s_axil_bvalid  (s_axil_bvalid),
        .s_axil_bready  (s_axil_bready),
        .s_axil_araddr  (s_axil_araddr),
        .s_axil_arprot  (s_axil_arprot),
        .s_axil_arvalid (s_axil_arvalid),
        .s_axil_arready (s_axil_arready),
        .s_axil_rdata   (s_axil_rdata),
        .s_axil_rresp   (s_axil_rresp),
        .s_axil_rvalid  (s_axil_rvalid),
        .s_axil_rready  (s_axil_rready),
        .reg_out        (reg_out),
        .reg_wr         (reg_wr)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int errors = 0;
    int checks = 0;

    logic sawAw;
    logic sawW;
    logic sawAr;

    // Transaction-level model state.
    logic [31:0] mRegs [16];
    logic [15:0] awQ [$];
    logic [35:0] wQ [$];
    logic        bPend;
    logic [1:0]  bRespM;
    logic [15:0] regWrM;
    logic        rPend;
    logic [31:0] rDataM;
    logic [1:0]  rRespM;

    task automatic checkOutput(input string name, input logic [511:0] actual,
                               input logic [511:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [511:0] modelFlat();
        logic [511:0] f;
        for (int i = 0; i < 16; i++) f[i*32 +: 32] = mRegs[i];
        return f;
    endfunction

    // Every cycle: compare all outputs with the model, then move the model
    // across the coming clock edge using the inputs the bench is driving.
    always @(negedge aclk) begin : compareProc
        logic [15:0] a;
        logic [35:0] w;
        int          idx;
        logic        awHs;
        logic        wHs;
        logic        arHs;
        if (arst) begin
            checkOutput("awreadyInReset", s_axil_awready, 0);
            checkOutput("wreadyInReset", s_axil_wready, 0);
            checkOutput("arreadyInReset", s_axil_arready, 0);
            for (int i = 0; i < 16; i++) mRegs[i] = RESET_VAL;
            awQ.delete();
            wQ.delete();
            bPend  = 1'b0;
            bRespM = 2'b00;
            regWrM = '0;
            rPend  = 1'b0;
            rDataM = '0;
            rRespM = 2'b00;
        end else begin
            checkOutput("bvalid", s_axil_bvalid, bPend);
            if (bPend) checkOutput("bresp", s_axil_bresp, bRespM);
            checkOutput("regWr", reg_wr, regWrM);
            checkOutput("regOut", reg_out, modelFlat());
            checkOutput("awready", s_axil_awready, awQ.size() == 0);
            checkOutput("wready", s_axil_wready, wQ.size() == 0);
            checkOutput("arready", s_axil_arready, !rPend || s_axil_rready);
            checkOutput("rvalid", s_axil_rvalid, rPend);
            if (rPend) begin
                checkOutput("rdata", s_axil_rdata, rDataM);
                checkOutput("rresp", s_axil_rresp, rRespM);
            end

            awHs = s_axil_awvalid && (awQ.size() == 0);
            wHs  = s_axil_wvalid && (wQ.size() == 0);
            arHs = s_axil_arvalid && (!rPend || s_axil_rready);
            if (awHs) awQ.push_back(s_axil_awaddr);
            if (wHs) wQ.push_back({s_axil_wstrb, s_axil_wdata});

            if (arHs) begin
                idx   = int'(s_axil_araddr >> 2);
                rPend = 1'b1;
                if (idx < 16) begin
                    rDataM = mRegs[idx];
                    rRespM = 2'b00;
                end else begin
                    rDataM = '0;
                    rRespM = 2'b10;
                end
            end else if (s_axil_rready) begin
                rPend = 1'b0;
            end

            regWrM = '0;
            if (awQ.size() > 0 && wQ.size() > 0 && (!bPend || s_axil_bready)) begin
                a     = awQ.pop_front();
                w     = wQ.pop_front();
                idx   = int'(a >> 2);
                bPend = 1'b1;
                if (idx < 16) begin
                    for (int k = 0; k < 4; k++) begin
                        if (w[32+k]) mRegs[idx][k*8 +: 8] = w[k*8 +: 8];
                    end
                    regWrM[idx] = 1'b1;
                    bRespM      = 2'b00;
                end else begin
                    bRespM = 2'b10;
                end
            end else if (s_axil_bready) begin
                bPend = 1'b0;
            end
        end
    end

    // Drive one cycle of channel inputs and note which handshakes happened.
    task automatic applyStimulus(input logic awv, input logic [15:0] awa,
                                 input logic wv, input logic [31:0] wd,
                                 input logic [3:0] ws, input logic arv,
                                 input logic [15:0] ara);
        s_axil_awvalid = awv;
        s_axil_awaddr  = awa;
        s_axil_wvalid  = wv;
        s_axil_wdata   = wd;
        s_axil_wstrb   = ws;
        s_axil_arvalid = arv;
        s_axil_araddr  = ara;
        @(negedge aclk);
        sawAw = s_axil_awvalid && s_axil_awready;
        sawW  = s_axil_wvalid && s_axil_wready;
        sawAr = s_axil_arvalid && s_axil_arready;
        @(posedge aclk);
        #1;
    endtask

    task automatic dropValids();
        s_axil_awvalid = 1'b0;
        s_axil_wvalid  = 1'b0;
        s_axil_arvalid = 1'b0;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 16'h0, 1'b0, 32'h0, 4'h0, 1'b0, 16'h0);
    endtask

    task automatic writeReg(input logic [15:0] addr, input logic [31:0] data,
                            input logic [3:0] strb);
        logic awPend;
        logic wPend;
        int   n;
        awPend = 1'b1;
        wPend  = 1'b1;
        n      = 0;
        while ((awPend || wPend) && n < 40) begin
            applyStimulus(awPend, addr, wPend, data, strb, 1'b0, 16'h0);
            if (sawAw) awPend = 1'b0;
            if (sawW) wPend = 1'b0;
            n++;
        end
        dropValids();
        if (awPend || wPend) checkOutput("writeHandshakeTimeout", 1, 0);
    endtask

    task automatic readReg(input logic [15:0] addr, output logic [31:0] data,
                           output logic [1:0] resp, output int lat);
        logic arPend;
        int   n;
        arPend = 1'b1;
        n      = 0;
        data   = 32'hxxxxxxxx;
        resp   = 2'bxx;
        lat    = 99;
        while (arPend && n < 40) begin
            applyStimulus(1'b0, 16'h0, 1'b0, 32'h0, 4'h0, 1'b1, addr);
            if (sawAr) arPend = 1'b0;
            n++;
        end
        dropValids();
        if (arPend) begin
            checkOutput("readHandshakeTimeout", 1, 0);
        end else begin
            for (int i = 1; i <= 20; i++) begin
                @(negedge aclk);
                if (s_axil_rvalid) begin
                    lat  = i;
                    data = s_axil_rdata;
                    resp = s_axil_rresp;
                    break;
                end
            end
            @(posedge aclk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;

        arst          = 1'b1;
        s_axil_awprot = 3'b000;
        s_axil_arprot = 3'b000;
        s_axil_bready = 1'b1;
        s_axil_rready = 1'b1;
        dropValids();
        s_axil_awaddr = '0;
        s_axil_wdata  = '0;
        s_axil_wstrb  = '0;
        s_axil_araddr = '0;
        repeat (3) @(posedge aclk);
        #1;
        arst = 1'b0;

        // Reset state and first read.
        @(negedge aclk);
        checkOutput("t1BvalidAfterReset", s_axil_bvalid, 0);
        checkOutput("t1RvalidAfterReset", s_axil_rvalid, 0);
        checkOutput("t1RegOutAfterReset", reg_out, 0);
        @(posedge aclk);
        #1;
        readReg(16'h000C, d, r, lat);
        checkOutput("t1ReadData", d, RESET_VAL);
        checkOutput("t1ReadResp", r, 2'b00);
        checkOutput("t1ReadLatency", lat, 1);

        // Full-word write, then partial strobes on the same register.
        writeReg(16'h0008, 32'hDEADBEEF, 4'b1111);
        @(negedge aclk);
        checkOutput("t2Bvalid", s_axil_bvalid, 1);
        checkOutput("t2Bresp", s_axil_bresp, 2'b00);
        checkOutput("t2RegWr", reg_wr, 16'h0004);
        checkOutput("t2Reg2", reg_out[64 +: 32], 32'hDEADBEEF);
        @(posedge aclk);
        #1;
        writeReg(16'h0008, 32'h11223344, 4'b0101);
        @(negedge aclk);
        checkOutput("t2Reg2Strobed", reg_out[64 +: 32], 32'hDE22BE44);
        @(posedge aclk);
        #1;

        // W leads AW by three cycles.
        applyStimulus(1'b0, 16'h0, 1'b1, 32'h5A5A5A5A, 4'hF, 1'b0, 16'h0);
        checkOutput("t3WHandshake", sawW, 1);
        dropValids();
        @(negedge aclk);
        checkOutput("t3WreadyHeld", s_axil_wready, 0);
        checkOutput("t3AwreadyFree", s_axil_awready, 1);
        @(posedge aclk);
        #1;
        idleCycle();
        applyStimulus(1'b1, 16'h0004, 1'b0, 32'h0, 4'h0, 1'b0, 16'h0);
        checkOutput("t3AwHandshake", sawAw, 1);
        dropValids();
        @(negedge aclk);
        checkOutput("t3Bvalid", s_axil_bvalid, 1);
        checkOutput("t3Reg1", reg_out[32 +: 32], 32'h5A5A5A5A);
        checkOutput("t3RegWr", reg_wr, 16'h0002);
        @(posedge aclk);
        #1;

        // B stalled across two back-to-back writes.
        s_axil_bready = 1'b0;
        writeReg(16'h0018, 32'hAAAA0001, 4'hF);
        writeReg(16'h001C, 32'hBBBB0002, 4'hF);
        @(negedge aclk);
        checkOutput("t4AwreadyStalled", s_axil_awready, 0);
        checkOutput("t4WreadyStalled", s_axil_wready, 0);
        checkOutput("t4Reg6", reg_out[192 +: 32], 32'hAAAA0001);
        checkOutput("t4Reg7NotYet", reg_out[224 +: 32], 32'h0);
        @(posedge aclk);
        #1;
        idleCycle();
        idleCycle();
        s_axil_bready = 1'b1;
        @(negedge aclk);
        checkOutput("t4B1Valid", s_axil_bvalid, 1);
        @(posedge aclk);
        #1;
        @(negedge aclk);
        checkOutput("t4B2Valid", s_axil_bvalid, 1);
        checkOutput("t4Reg7", reg_out[224 +: 32], 32'hBBBB0002);
        checkOutput("t4RegWr7", reg_wr, 16'h0080);
        @(posedge aclk);
        #1;
        @(negedge aclk);
        checkOutput("t4BDrained", s_axil_bvalid, 0);
        @(posedge aclk);
        #1;

        // Out-of-range read and write.
        readReg(16'h0040, d, r, lat);
        checkOutput("t5ReadData", d, 32'h0);
        checkOutput("t5ReadResp", r, 2'b10);
        writeReg(16'h0040, 32'hFFFFFFFF, 4'hF);
        @(negedge aclk);
        checkOutput("t5Bresp", s_axil_bresp, 2'b10);
        checkOutput("t5RegWr", reg_wr, 16'h0);
        checkOutput("t5Reg2Kept", reg_out[64 +: 32], 32'hDE22BE44);
        @(posedge aclk);
        #1;

        // Same-edge read and write of register 5.
        writeReg(16'h0014, 32'h00000001, 4'hF);
        idleCycle();
        applyStimulus(1'b1, 16'h0014, 1'b1, 32'h00000002, 4'hF, 1'b1, 16'h0014);
        checkOutput("t6AllHandshakes", {sawAw, sawW, sawAr}, 3'b111);
        dropValids();
        @(negedge aclk);
        checkOutput("t6ReadOld", s_axil_rdata, 32'h1);
        checkOutput("t6Reg5New", reg_out[160 +: 32], 32'h2);
        @(posedge aclk);
        #1;
        readReg(16'h0014, d, r, lat);
        checkOutput("t6ReadNew", d, 32'h2);

        // Reset with B and R both pending.
        s_axil_bready = 1'b0;
        s_axil_rready = 1'b0;
        writeReg(16'h0020, 32'h00000077, 4'hF);
        readReg(16'h0014, d, r, lat);
        @(negedge aclk);
        checkOutput("t6BPendingPreReset", s_axil_bvalid, 1);
        checkOutput("t6RPendingPreReset", s_axil_rvalid, 1);
        @(posedge aclk);
        #1;
        arst = 1'b1;
        @(negedge aclk);
        checkOutput("t6ArreadyInReset", s_axil_arready, 0);
        @(posedge aclk);
        #1;
        arst          = 1'b0;
        s_axil_bready = 1'b1;
        s_axil_rready = 1'b1;
        @(negedge aclk);
        checkOutput("t6BvalidCleared", s_axil_bvalid, 0);
        checkOutput("t6RvalidCleared", s_axil_rvalid, 0);
        checkOutput("t6RegsReset", reg_out, 0);
        @(posedge aclk);
        #1;
        idleCycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
